// File: rtl/fp_add_unit.sv
// fp_add_unit: registered IEEE-754-style floating-point adder, one cycle latency.
// Zero and denormal operands are flushed to zero; all-ones exponents give infinity.
// Rounding is truncation by default. Defining FPA_ROUND_NEAREST_EN switches to
// round-to-nearest, ties-to-even, using the guard/round/sticky bits.
module fp_add_unit #(
    parameter int  EXP_WIDTH      = 8,
    parameter int  MANTISSA_WIDTH = 23,
    localparam int W              = 1 + EXP_WIDTH + MANTISSA_WIDTH
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] fpa_out,
    output logic         overflow_out,
    output logic         underflow_out
);

    localparam int EW = EXP_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    // hidden bit + fraction + guard/round/sticky
    localparam int SW = MW + 4;
    // signed working exponent, wide enough for the largest left normalization
    localparam int XW = EW + $clog2(MW + 4) + 2;

    localparam logic [EW-1:0]        EXP_ONES = '1;
    localparam logic signed [XW-1:0] EXP_MAX  = {{(XW-EW){1'b0}}, EXP_ONES};

    logic              sa, sb, sl;
    logic [EW-1:0]     ea, eb, el, es, diff;
    logic              a_zero, b_zero, a_spec, b_spec;
    logic [W-2:0]      mag_a, mag_b;
    logic [MW:0]       ma, mb, ml, ms;
    logic [SW-1:0]     l_ext, s_ext, shifted, norm;
    logic [SW:0]       sum;
    logic              lost;
    int                lz;
    logic signed [XW-1:0] exp_n;
    logic [MW-1:0]     frac;
    logic [W-1:0]      res;
    logic              res_ovf, res_unf;
    logic              unused_bits;
`ifdef FPA_ROUND_NEAREST_EN
    logic              round_up;
    logic [MW+1:0]     mant_r;
`endif

    // Combinational datapath: align, add/subtract, normalize, round, classify
    always_comb begin
        sa     = a_in[W-1];
        sb     = b_in[W-1];
        ea     = a_in[W-2:MW];
        eb     = b_in[W-2:MW];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_spec = (ea == EXP_ONES);
        b_spec = (eb == EXP_ONES);
        ma     = a_zero ? '0 : {1'b1, a_in[MW-1:0]};
        mb     = b_zero ? '0 : {1'b1, b_in[MW-1:0]};
        mag_a  = a_zero ? '0 : a_in[W-2:0];
        mag_b  = b_zero ? '0 : b_in[W-2:0];

        // larger magnitude goes first; its sign is the result sign
        if (mag_a >= mag_b) begin
            sl = sa; el = ea; ml = ma; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb; es = ea; ms = ma;
        end
        diff = el - es;

        l_ext   = {ml, 3'b000};
        s_ext   = {ms, 3'b000};
        shifted = '0;
        lost    = 1'b0;
        if (int'(diff) < MW + 3) begin
            shifted    = s_ext >> diff;
            lost       = |(s_ext & ~({SW{1'b1}} << diff));
            shifted[0] = shifted[0] | lost;
        end

        if (sa == sb) sum = {1'b0, l_ext} + {1'b0, shifted};
        else          sum = {1'b0, l_ext} - {1'b0, shifted};

        exp_n = $signed({{(XW-EW){1'b0}}, el});
        lz    = 0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lz = SW - 1 - i;
        end
        if (sum[SW]) begin
            // carry out: shift right, fold the dropped bit into sticky
            norm    = sum[SW:1];
            norm[0] = sum[1] | sum[0];
            exp_n   = exp_n + 1;
        end else begin
            norm  = sum[SW-1:0] << lz;
            exp_n = exp_n - XW'(lz);
        end

`ifdef FPA_ROUND_NEAREST_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[SW-1:3]} + (MW+2)'(round_up);
        if (mant_r[MW+1]) begin
            frac  = mant_r[MW:1];
            exp_n = exp_n + 1;
        end else begin
            frac  = mant_r[MW-1:0];
        end
`else
        frac = norm[SW-2:3];
`endif
        unused_bits = ^{norm[SW-1], norm[2:0]};

        res     = '0;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        if (a_spec || b_spec) begin
            res     = {(a_spec ? sa : sb), EXP_ONES, {MW{1'b0}}};
            res_ovf = 1'b1;
        end else if (sum == '0) begin
            res = '0;
        end else if (exp_n >= EXP_MAX) begin
            res     = {sl, EXP_ONES, {MW{1'b0}}};
            res_ovf = 1'b1;
        end else if (exp_n <= 0) begin
            res     = '0;
            res_unf = 1'b1;
        end else begin
            res = {sl, exp_n[EW-1:0], frac};
        end
    end

    // Output register with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fpa_out       <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            fpa_out       <= res;
            overflow_out  <= res_ovf;
            underflow_out <= res_unf;
        end
    end

endmodule

// File: tb/tb_fp_add_unit.sv
// Directed-vector bench for fp_add_unit (single precision defaults).
module tb_fp_add_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] a_in, b_in, fpa_out;
    logic        overflow_out, underflow_out;

    int checks = 0;
    int errors = 0;

    fp_add_unit dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .fpa_out       (fpa_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    task automatic check_outputs(input string tag, input logic [31:0] sum, input logic ovf, input logic unf);
        chk({tag, "_sum"}, fpa_out, sum);
        chk({tag, "_ovf"}, {31'b0, overflow_out}, {31'b0, ovf});
        chk({tag, "_unf"}, {31'b0, underflow_out}, {31'b0, unf});
        chk({tag, "_excl"}, {31'b0, overflow_out & underflow_out}, 32'h0);
    endtask

    initial begin
        vecs.push_back('{"basic",     32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0});
        vecs.push_back('{"cancel",    32'h3FC00000, 32'hBFC00000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0});
        vecs.push_back('{"ovf_neg",   32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1, 1'b0});
        vecs.push_back('{"unf",       32'h00800001, 32'h80800000, 32'h00000000, 1'b0, 1'b1});
`ifdef FPA_ROUND_NEAREST_EN
        vecs.push_back('{"tie",       32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0});
        vecs.push_back('{"rnd_ovf",   32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b1, 1'b0});
`else
        vecs.push_back('{"tie",       32'h3F800001, 32'h33800000, 32'h3F800001, 1'b0, 1'b0});
        vecs.push_back('{"rnd_ovf",   32'h7F7FFFFF, 32'h73000000, 32'h7F7FFFFF, 1'b0, 1'b0});
`endif
        vecs.push_back('{"tie_even",  32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 1'b0});
        vecs.push_back('{"zero_x",    32'h00000000, 32'hC0A00000, 32'hC0A00000, 1'b0, 1'b0});
        vecs.push_back('{"denorm",    32'h00000123, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0});
        vecs.push_back('{"inf_a",     32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0});
        vecs.push_back('{"inf_sign_a",32'hFF800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0});
        vecs.push_back('{"nan_b",     32'h3F800000, 32'hFFC00000, 32'hFF800000, 1'b1, 1'b0});
        vecs.push_back('{"sub_pos",   32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0});
        vecs.push_back('{"sub_neg",   32'h3F800000, 32'hC0400000, 32'hC0000000, 1'b0, 1'b0});
        vecs.push_back('{"sub_norm",  32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 1'b0, 1'b0});
        vecs.push_back('{"far_shift", 32'h3F800000, 32'h32000000, 32'h3F800000, 1'b0, 1'b0});

        // reset with live operands present
        rst_in = 1'b1;
        a_in   = 32'h3F800000;
        b_in   = 32'h40000000;
        @(posedge clk_in); #1;
        check_outputs("reset", 32'h0, 1'b0, 1'b0);

        rst_in = 1'b0;
        foreach (vecs[i]) begin
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            @(posedge clk_in); #1;
            check_outputs(vecs[i].tag, vecs[i].sum, vecs[i].ovf, vecs[i].unf);
        end

        // reset mid-stream, then resume
        a_in = 32'h7F7FFFFF;
        b_in = 32'h7F7FFFFF;
        @(posedge clk_in); #1;
        check_outputs("pre_rst", 32'h7F800000, 1'b1, 1'b0);
        rst_in = 1'b1;
        a_in   = 32'h40400000;
        b_in   = 32'hBF800000;
        @(posedge clk_in); #1;
        check_outputs("mid_rst", 32'h0, 1'b0, 1'b0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check_outputs("post_rst", 32'h40000000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
